// File: rtl/ula_arbiter_if.sv
// Request/response bus between the two ULA requesters (plus the response consumer)
// and the ula_arbiter.
interface ula_arbiter_if #(
  parameter int W = 6
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_mode;
  logic [2:0]   req0_oper;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_mode;
  logic [2:0]   req1_oper;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_o;
  logic         rsp_overflow;
  logic         rsp_zero;

  modport master (
    output req_valid, req0_a, req0_b, req0_mode, req0_oper,
           req1_a, req1_b, req1_mode, req1_oper, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_o, rsp_overflow, rsp_zero
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_mode, req0_oper,
           req1_a, req1_b, req1_mode, req1_oper, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_o, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters; the
// winner's operation is latched, held on the ULA and its result returned with its id.
module ula_arbiter #(
  parameter int W           = 6,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  ula_arbiter_if.slave bus,
  output logic         busy,
  output logic [W-1:0] ula_a,
  output logic [W-1:0] ula_b,
  output logic         ula_mode,
  output logic [2:0]   ula_oper,
  output logic         ula_reset,
  input  logic [W-1:0] ula_o,
  input  logic         ula_overflow,
  input  logic         ula_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

  state_t        state;
  logic          last;
  logic          opId;
  logic [CW-1:0] cnt;
  logic [1:0]    grant;

  // On a tie the requester that was not served last wins; grants only while idle.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign busy          = (state != IDLE);
  assign ula_reset     = reset;

  // The op registers drive the ULA directly, so its inputs stay put outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      last             <= 1'b1;
      opId             <= 1'b0;
      cnt              <= '0;
      ula_a            <= '0;
      ula_b            <= '0;
      ula_mode         <= 1'b0;
      ula_oper         <= 3'd0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= 1'b0;
      bus.rsp_o        <= '0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            opId     <= grant[1];
            ula_a    <= grant[1] ? bus.req1_a    : bus.req0_a;
            ula_b    <= grant[1] ? bus.req1_b    : bus.req0_b;
            ula_mode <= grant[1] ? bus.req1_mode : bus.req0_mode;
            ula_oper <= grant[1] ? bus.req1_oper : bus.req0_oper;
            cnt      <= CNT_LOAD;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            bus.rsp_o        <= ula_o;
            bus.rsp_zero     <= ula_zero;
            bus.rsp_overflow <= ula_overflow & ~ula_mode;
            bus.rsp_id       <= opId;
            bus.rsp_valid    <= 1'b1;
            last             <= opId;
            state            <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Drives two arbiters (EXEC_CYCLES 1 and 3) with directed and random traffic and checks
// them against a transaction-level model of arbitration, latency and ULA results.
module tb_ula_arbiter;
  localparam int W     = 6;
  localparam int EXEC0 = 1;
  localparam int EXEC1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst     [2];
  logic         busyS   [2];
  logic [W-1:0] ulaA    [2];
  logic [W-1:0] ulaB    [2];
  logic         ulaMode [2];
  logic [2:0]   ulaOper [2];
  logic         ulaRst  [2];
  logic [W-1:0] ulaO    [2];
  logic         ulaOvf  [2];
  logic         ulaZero [2];

  ula_arbiter_if #(.W(W)) bus0 ();
  ula_arbiter_if #(.W(W)) bus1 ();

  ula_arbiter #(.W(W), .EXEC_CYCLES(EXEC0)) dut0 (
    .clk(clk), .reset(rst[0]), .bus(bus0.slave), .busy(busyS[0]),
    .ula_a(ulaA[0]), .ula_b(ulaB[0]), .ula_mode(ulaMode[0]), .ula_oper(ulaOper[0]),
    .ula_reset(ulaRst[0]), .ula_o(ulaO[0]), .ula_overflow(ulaOvf[0]), .ula_zero(ulaZero[0])
  );

  ula_arbiter #(.W(W), .EXEC_CYCLES(EXEC1)) dut1 (
    .clk(clk), .reset(rst[1]), .bus(bus1.slave), .busy(busyS[1]),
    .ula_a(ulaA[1]), .ula_b(ulaB[1]), .ula_mode(ulaMode[1]), .ula_oper(ulaOper[1]),
    .ula_reset(ulaRst[1]), .ula_o(ulaO[1]), .ula_overflow(ulaOvf[1]), .ula_zero(ulaZero[1])
  );

  // Stand-in ULA; its raw flag for logic ops is deliberately junk so masking is visible.
  function automatic logic [W:0] ulaCalc(input logic mode, input logic [2:0] oper,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] ea, eb, one, r;
    ea  = {1'b0, a};
    eb  = {1'b0, b};
    one = (W+1)'(1);
    r   = '0;
    if (!mode) begin
      case (oper)
        3'd0:    r = ea + eb;
        3'd1:    r = ea - eb;
        3'd2:    r = ea + one;
        3'd3:    r = eb - ea;
        3'd4:    r = eb + one;
        3'd5:    r = ea - one;
        3'd6:    r = eb - one;
        default: r = ea;
      endcase
    end else begin
      case (oper)
        3'd0:    r = {a[0] ^ b[0], a & b};
        3'd1:    r = {a[0] ^ b[0], a | b};
        3'd2:    r = {a[0] ^ b[0], a ^ b};
        3'd3:    r = {a[0] ^ b[0], ~a};
        3'd4:    r = {a[0] ^ b[0], ~(a & b)};
        3'd5:    r = {a[0] ^ b[0], ~(a | b)};
        3'd6:    r = {a[0] ^ b[0], ~(a ^ b)};
        default: r = {a[0] ^ b[0], b};
      endcase
    end
    return r;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      logic [W:0] r;
      r          = ulaCalc(ulaMode[d], ulaOper[d], ulaA[d], ulaB[d]);
      ulaOvf[d]  = r[W];
      ulaO[d]    = r[W-1:0];
      ulaZero[d] = (r[W-1:0] == '0);
    end
  end

  logic [1:0]   obsReady    [2];
  logic         obsRspValid [2];
  logic         obsRspId    [2];
  logic [W-1:0] obsRspO     [2];
  logic         obsRspOvf   [2];
  logic         obsRspZero  [2];

  assign obsReady[0]    = bus0.req_ready;
  assign obsRspValid[0] = bus0.rsp_valid;
  assign obsRspId[0]    = bus0.rsp_id;
  assign obsRspO[0]     = bus0.rsp_o;
  assign obsRspOvf[0]   = bus0.rsp_overflow;
  assign obsRspZero[0]  = bus0.rsp_zero;
  assign obsReady[1]    = bus1.req_ready;
  assign obsRspValid[1] = bus1.rsp_valid;
  assign obsRspId[1]    = bus1.rsp_id;
  assign obsRspO[1]     = bus1.rsp_o;
  assign obsRspOvf[1]   = bus1.rsp_overflow;
  assign obsRspZero[1]  = bus1.rsp_zero;

  bit           pend    [2][2];
  logic [W-1:0] rA      [2][2];
  logic [W-1:0] rB      [2][2];
  logic         rMode   [2][2];
  logic [2:0]   rOper   [2][2];
  bit           rspRdy  [2];
  bit           rstStim [2];

  bit           inFlight [2];
  bit           rspPend  [2];
  bit           lastId   [2];
  int           waitCnt  [2];
  logic [W-1:0] capA     [2];
  logic [W-1:0] capB     [2];
  logic         capMode  [2];
  logic [2:0]   capOper  [2];
  logic [W-1:0] expO     [2];
  logic         expOvf   [2];
  logic         expZero  [2];
  logic         expId    [2];

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int execOf(input int d);
    return (d == 0) ? EXEC0 : EXEC1;
  endfunction

  task automatic applyStimulus();
    @(negedge clk);
    rst[0]         = rstStim[0];
    rst[1]         = rstStim[1];
    bus0.req_valid = {pend[0][1], pend[0][0]};
    bus0.req0_a    = rA[0][0];  bus0.req0_b = rB[0][0];
    bus0.req0_mode = rMode[0][0]; bus0.req0_oper = rOper[0][0];
    bus0.req1_a    = rA[0][1];  bus0.req1_b = rB[0][1];
    bus0.req1_mode = rMode[0][1]; bus0.req1_oper = rOper[0][1];
    bus0.rsp_ready = rspRdy[0];
    bus1.req_valid = {pend[1][1], pend[1][0]};
    bus1.req0_a    = rA[1][0];  bus1.req0_b = rB[1][0];
    bus1.req0_mode = rMode[1][0]; bus1.req0_oper = rOper[1][0];
    bus1.req1_a    = rA[1][1];  bus1.req1_b = rB[1][1];
    bus1.req1_mode = rMode[1][1]; bus1.req1_oper = rOper[1][1];
    bus1.rsp_ready = rspRdy[1];
  endtask

  // Transaction view: an accepted op answers after its EXEC count, then waits for rsp_ready.
  task automatic modelCycle();
    for (int d = 0; d < 2; d++) begin
      bit         idle;
      int         win;
      logic [W:0] r;
      idle = !inFlight[d] && !rspPend[d];
      win  = -1;
      if (idle) begin
        if (pend[d][0] && pend[d][1]) win = lastId[d] ? 0 : 1;
        else if (pend[d][0])          win = 0;
        else if (pend[d][1])          win = 1;
      end
      checkOutput($sformatf("d%0d.ulaReset", d), 32'(ulaRst[d]), 32'(rstStim[d]));
      if (!rstStim[d]) begin
        checkOutput($sformatf("d%0d.reqReady", d), 32'(obsReady[d]), (win < 0) ? 32'd0 : (32'd1 << win));
        checkOutput($sformatf("d%0d.busy", d), 32'(busyS[d]), 32'(!idle));
        checkOutput($sformatf("d%0d.rspValid", d), 32'(obsRspValid[d]), 32'(rspPend[d]));
        checkOutput($sformatf("d%0d.ulaA", d), 32'(ulaA[d]), 32'(capA[d]));
        checkOutput($sformatf("d%0d.ulaB", d), 32'(ulaB[d]), 32'(capB[d]));
        checkOutput($sformatf("d%0d.ulaModeOper", d), 32'({ulaMode[d], ulaOper[d]}),
                    32'({capMode[d], capOper[d]}));
        if (rspPend[d]) begin
          checkOutput($sformatf("d%0d.rspId", d), 32'(obsRspId[d]), 32'(expId[d]));
          checkOutput($sformatf("d%0d.rspO", d), 32'(obsRspO[d]), 32'(expO[d]));
          checkOutput($sformatf("d%0d.rspOvf", d), 32'(obsRspOvf[d]), 32'(expOvf[d]));
          checkOutput($sformatf("d%0d.rspZero", d), 32'(obsRspZero[d]), 32'(expZero[d]));
        end
      end
      if (rstStim[d]) begin
        inFlight[d] = 0; rspPend[d] = 0; lastId[d] = 1;
        capA[d] = '0; capB[d] = '0; capMode[d] = 1'b0; capOper[d] = 3'd0;
      end else if (win >= 0) begin
        capA[d]     = rA[d][win];
        capB[d]     = rB[d][win];
        capMode[d]  = rMode[d][win];
        capOper[d]  = rOper[d][win];
        r           = ulaCalc(capMode[d], capOper[d], capA[d], capB[d]);
        expO[d]     = r[W-1:0];
        expOvf[d]   = capMode[d] ? 1'b0 : r[W];
        expZero[d]  = (r[W-1:0] == '0);
        expId[d]    = (win == 1);
        inFlight[d] = 1;
        waitCnt[d]  = execOf(d);
        pend[d][win] = 0;
      end else if (inFlight[d]) begin
        waitCnt[d]--;
        if (waitCnt[d] == 0) begin
          inFlight[d] = 0;
          rspPend[d]  = 1;
          lastId[d]   = expId[d];
        end
      end else if (rspPend[d] && rspRdy[d]) begin
        rspPend[d] = 0;
      end
    end
  endtask

  task automatic stepCycle();
    applyStimulus();
    #1;
    modelCycle();
  endtask

  task automatic setReq(input int d, input int k, input logic mode, input logic [2:0] oper,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    pend[d][k] = 1; rMode[d][k] = mode; rOper[d][k] = oper; rA[d][k] = a; rB[d][k] = b;
  endtask

  function automatic logic [W-1:0] pickVal();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom_range(0, (1 << W) - 1));
    endcase
  endfunction

  task automatic newOp(input int d, input int k);
    setReq(d, k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pickVal(), pickVal());
  endtask

  function automatic bit quiet();
    for (int d = 0; d < 2; d++)
      if (pend[d][0] || pend[d][1] || inFlight[d] || rspPend[d]) return 0;
    return 1;
  endfunction

  task automatic runUntilQuiet(input int maxCycles);
    int n = 0;
    while (n < maxCycles && !quiet()) begin
      stepCycle();
      n++;
    end
    if (!quiet()) checkOutput("quietTimeout", 32'd0, 32'd1);
  endtask

  // Traffic phases rotate between both requesters, only req0 and only req1.
  task automatic randomStim(input int cyc);
    int phase = (cyc / 250) % 3;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        bit active = (phase == 0) || (phase == 1 && k == 0) || (phase == 2 && k == 1);
        if (!pend[d][k]) begin
          if (active && $urandom_range(0, 99) < 50) newOp(d, k);
        end else if ($urandom_range(0, 99) < 3) begin
          pend[d][k] = 0;
        end
      end
      rspRdy[d]  = ($urandom_range(0, 99) < 65);
      rstStim[d] = ($urandom_range(0, 299) == 0);
    end
  endtask

  initial begin
    int n;
    rstStim = '{1, 1};
    rspRdy  = '{1, 1};
    stepCycle();
    stepCycle();
    rstStim = '{0, 0};
    stepCycle();
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d.rstRspO", d), 32'(obsRspO[d]), 32'd0);
      checkOutput($sformatf("d%0d.rstRspFlags", d),
                  32'({obsRspId[d], obsRspOvf[d], obsRspZero[d]}), 32'd0);
    end

    $display("[TB] overflowing add on req0");
    for (int d = 0; d < 2; d++) setReq(d, 0, 1'b0, 3'd0, 6'd63, 6'd1);
    runUntilQuiet(20);

    $display("[TB] simultaneous requests, alternating grants");
    for (int d = 0; d < 2; d++) begin
      setReq(d, 0, 1'b0, 3'd1, 6'd5, 6'd9);
      setReq(d, 1, 1'b1, 3'd2, 6'd33, 6'd12);
    end
    for (int c = 0; c < 40; c++) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 2; k++)
          if (!pend[d][k]) newOp(d, k);
      stepCycle();
    end
    runUntilQuiet(30);

    $display("[TB] logic AND on req1 after an overflowing add");
    for (int d = 0; d < 2; d++) setReq(d, 0, 1'b0, 3'd0, 6'd40, 6'd30);
    runUntilQuiet(20);
    for (int d = 0; d < 2; d++) setReq(d, 1, 1'b1, 3'd0, 6'h2A, 6'h0F);
    runUntilQuiet(20);

    $display("[TB] response stall");
    rspRdy = '{0, 0};
    for (int d = 0; d < 2; d++) setReq(d, 0, 1'b0, 3'd2, 6'd62, 6'd7);
    n = 0;
    while (!(rspPend[0] && rspPend[1]) && n < 20) begin
      stepCycle();
      n++;
    end
    if (!(rspPend[0] && rspPend[1])) checkOutput("stallTimeout", 32'd0, 32'd1);
    for (int d = 0; d < 2; d++) setReq(d, 1, 1'b1, 3'd1, 6'd3, 6'd48);
    for (int c = 0; c < 5; c++) stepCycle();
    rspRdy = '{1, 1};
    runUntilQuiet(30);

    $display("[TB] reset during EXEC");
    for (int d = 0; d < 2; d++) begin
      setReq(d, 0, 1'b0, 3'd0, 6'd10, 6'd20);
      setReq(d, 1, 1'b0, 3'd1, 6'd10, 6'd20);
    end
    stepCycle();
    rstStim = '{1, 1};
    stepCycle();
    rstStim = '{0, 0};
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 2; k++)
        if (!pend[d][k]) setReq(d, k, 1'b1, 3'd3, 6'd21, 6'd0);
    stepCycle();
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("d%0d.grantAfterReset", d), 32'(expId[d]), 32'd0);
    runUntilQuiet(30);

    $display("[TB] A-1 with A=0");
    for (int d = 0; d < 2; d++) setReq(d, 0, 1'b0, 3'd5, 6'd0, 6'd17);
    runUntilQuiet(20);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      randomStim(c);
      stepCycle();
    end
    rstStim = '{0, 0};
    rspRdy  = '{1, 1};
    runUntilQuiet(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
